// File: rtl/smachine_pkg.sv
// Shared S-Machine definitions: instruction memory geometry and the
// program loader FSM state encoding.
package smachine_pkg;

  localparam int INST_ADDR_W = 8;
  localparam int INST_DATA_W = 16;
  localparam int COUNT_W     = 8;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_COUNT = 3'd1;
  localparam logic [2:0] ST_WORD  = 3'd2;
  localparam logic [2:0] ST_CHECK = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;
  localparam logic [2:0] ST_ERROR = 3'd5;

endpackage

// File: rtl/loader_shift.sv
// Serial-in MSB-first shift register with a bit counter; word_ready flags the
// cycle in which the last bit of an nbits-long field is being sampled.
module loader_shift #(
  parameter  int DATA_W = 16,
  localparam int CNT_W  = $clog2(DATA_W + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              shift_en,
  input  logic              bit_data,
  input  logic [CNT_W-1:0]  nbits,
  output logic [DATA_W-1:0] next_word,
  output logic              word_ready
);

  logic [DATA_W-1:0] shreg;
  logic [CNT_W-1:0]  cnt;

  // next_word already includes the bit being sampled, so the consumer can
  // register the complete field on the same edge that takes its last bit.
  assign next_word  = {shreg[DATA_W-2:0], bit_data};
  assign word_ready = shift_en && (cnt == nbits - CNT_W'(1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (shift_en) begin
      shreg <= next_word;
      cnt   <= word_ready ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/inst_loader.sv
// Serial program loader: deserialises count/words/checksum frames into
// instruction memory writes and gates the CPU enable on a verified load.
module inst_loader
  import smachine_pkg::*;
#(
  parameter int ADDR_W = INST_ADDR_W,
  parameter int DATA_W = INST_DATA_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load_start,
  input  logic              bit_valid,
  input  logic              bit_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              cpu_enable
);

  localparam int SH_CNT_W = $clog2(DATA_W + 1);

  logic [2:0]          state;
  logic [COUNT_W:0]    word_cnt;
  logic [COUNT_W:0]    n_words;
  logic [DATA_W-1:0]   sum;
  logic [DATA_W-1:0]   next_word;
  logic                word_ready;
  logic                shift_en;
  logic [SH_CNT_W-1:0] nbits;

  assign busy = (state == ST_COUNT) || (state == ST_WORD) || (state == ST_CHECK);
  // A bit coinciding with load_start belongs to the aborted frame and is dropped.
  assign shift_en = busy && bit_valid && !load_start;
  assign nbits    = (state == ST_COUNT) ? SH_CNT_W'(COUNT_W) : SH_CNT_W'(DATA_W);

  loader_shift #(.DATA_W(DATA_W)) u_shift (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (load_start),
    .shift_en   (shift_en),
    .bit_data   (bit_data),
    .nbits      (nbits),
    .next_word  (next_word),
    .word_ready (word_ready)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      word_cnt   <= '0;
      n_words    <= '0;
      sum        <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      done       <= 1'b0;
      error      <= 1'b0;
      cpu_enable <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      if (load_start) begin
        state      <= ST_COUNT;
        word_cnt   <= '0;
        sum        <= '0;
        done       <= 1'b0;
        error      <= 1'b0;
        cpu_enable <= 1'b0;
      end else if (word_ready) begin
        case (state)
          ST_COUNT: begin
            // A count byte of zero encodes a full 256-word image.
            n_words <= {~|next_word[COUNT_W-1:0], next_word[COUNT_W-1:0]};
            state   <= ST_WORD;
          end
          ST_WORD: begin
            wr_en    <= 1'b1;
            wr_addr  <= word_cnt[ADDR_W-1:0];
            wr_data  <= next_word;
            sum      <= sum + next_word;
            word_cnt <= word_cnt + (COUNT_W+1)'(1);
            if (word_cnt + (COUNT_W+1)'(1) == n_words) state <= ST_CHECK;
          end
          ST_CHECK: begin
            if (next_word == sum) begin
              state      <= ST_DONE;
              done       <= 1'b1;
              cpu_enable <= 1'b1;
            end else begin
              state <= ST_ERROR;
              error <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_inst_loader.sv
// Scoreboard bench for inst_loader: a driver serialises frames and queues the
// writes and status a correct loader must produce; a monitor checks every cycle.
module tb_inst_loader;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        load_start = 1'b0;
  logic        bit_valid = 1'b0;
  logic        bit_data = 1'b0;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [15:0] wr_data;
  logic        busy, done, error, cpu_enable;

  inst_loader #(.ADDR_W(8), .DATA_W(16)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_start (load_start),
    .bit_valid  (bit_valid),
    .bit_data   (bit_data),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .cpu_enable (cpu_enable)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] a; logic [15:0] d; } wr_t;
  wr_t exp_q[$];

  int   n_cmp = 0;
  int   n_bad = 0;
  int   gap_pct = 0;
  logic exp_en = 1'b0, exp_done = 1'b0, exp_err = 1'b0, exp_busy = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: samples 1 time unit after each active edge.
  always @(posedge clk) begin
    wr_t e;
    #1;
    if (wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write (t=%0t)",
                 wr_addr, wr_data, $time);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", {24'd0, wr_addr}, {24'd0, e.a});
        check("wr_data", {16'd0, wr_data}, {16'd0, e.d});
      end
    end
    check("cpu_enable", {31'd0, cpu_enable}, {31'd0, exp_en});
    check("done",       {31'd0, done},       {31'd0, exp_done});
    check("error",      {31'd0, error},      {31'd0, exp_err});
    check("busy",       {31'd0, busy},       {31'd0, exp_busy});
  end

  // Driver: inputs change on the falling edge.
  task automatic send_bit(input logic b, input bit last, input bit good);
    while ($urandom_range(0, 99) < gap_pct) begin
      bit_valid = 1'b0;
      @(negedge clk);
    end
    bit_valid = 1'b1;
    bit_data  = b;
    if (last) begin
      exp_busy = 1'b0;
      exp_en   = good;
      exp_done = good;
      exp_err  = !good;
    end
    @(negedge clk);
    bit_valid = 1'b0;
  endtask

  task automatic send_bits(input logic [15:0] v, input int nb, input bit last, input bit good);
    for (int i = nb - 1; i >= 0; i--) send_bit(v[i], last && (i == 0), good);
  endtask

  task automatic pulse_start(input bit with_bit);
    load_start = 1'b1;
    bit_valid  = with_bit;
    bit_data   = 1'b1;
    exp_en     = 1'b0;
    exp_done   = 1'b0;
    exp_err    = 1'b0;
    exp_busy   = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    bit_valid  = 1'b0;
  endtask

  task automatic send_frame(input logic [15:0] ws[$], input bit corrupt, input bit with_bit);
    logic [15:0] chk;
    wr_t w;
    chk = 16'h0;
    foreach (ws[i]) chk = chk + ws[i];
    if (corrupt) chk = chk ^ 16'h0001;
    pulse_start(with_bit);
    send_bits(16'(ws.size() % 256), 8, 1'b0, 1'b0);
    foreach (ws[i]) begin
      w.a = 8'(i);
      w.d = ws[i];
      exp_q.push_back(w);
      send_bits(ws[i], 16, 1'b0, 1'b0);
    end
    send_bits(chk, 16, 1'b1, !corrupt);
  endtask

  logic [15:0] ws[$];
  wr_t w;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst_wr_addr", {24'd0, wr_addr}, 32'd0);
    check("rst_wr_data", {16'd0, wr_data}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Good load
    ws = '{16'h1234, 16'hABCD};
    send_frame(ws, 1'b0, 1'b0);
    check("good_done", {31'd0, done}, 32'd1);
    check("good_last_addr", {24'd0, wr_addr}, 32'd1);

    // Bad checksum (0xBE00)
    send_frame(ws, 1'b1, 1'b0);
    check("bad_error", {31'd0, error}, 32'd1);

    // Full memory, N=0
    ws.delete();
    for (int i = 0; i < 256; i++) ws.push_back(16'(i) ^ 16'h5A5A);
    send_frame(ws, 1'b0, 1'b0);
    check("full_done", {31'd0, done}, 32'd1);
    check("full_last_addr", {24'd0, wr_addr}, 32'd255);
    check("full_queue", exp_q.size(), 32'd0);

    // Gapped good load
    gap_pct = 40;
    ws = '{16'h1234, 16'hABCD};
    send_frame(ws, 1'b0, 1'b0);
    check("gap_done", {31'd0, done}, 32'd1);
    gap_pct = 0;

    // Restart after 10 bits of the first word, with a coincident bit
    pulse_start(1'b0);
    send_bits(16'h0002, 8, 1'b0, 1'b0);
    send_bits(16'h03A5, 10, 1'b0, 1'b0);
    send_frame(ws, 1'b0, 1'b1);
    check("restart_done", {31'd0, done}, 32'd1);

    // Random frames
    for (int r = 0; r < 8; r++) begin
      ws.delete();
      for (int k = 0, n = $urandom_range(1, 20); k < n; k++) ws.push_back(16'($urandom));
      gap_pct = $urandom_range(0, 50);
      send_frame(ws, ($urandom_range(0, 3) == 0), 1'b0);
    end
    gap_pct = 0;

    // Reset during the checksum
    pulse_start(1'b0);
    send_bits(16'h0002, 8, 1'b0, 1'b0);
    foreach (ws[i]) begin
      if (i < 2) begin
        w.a = 8'(i);
        w.d = ws[i];
        exp_q.push_back(w);
        send_bits(ws[i], 16, 1'b0, 1'b0);
      end
    end
    send_bits(16'h7F, 7, 1'b0, 1'b0);
    exp_busy = 1'b0;
    exp_en   = 1'b0;
    exp_done = 1'b0;
    exp_err  = 1'b0;
    reset_n  = 1'b0;
    #1;
    check("mid_rst_wr_en",   {31'd0, wr_en},      32'd0);
    check("mid_rst_wr_addr", {24'd0, wr_addr},    32'd0);
    check("mid_rst_wr_data", {16'd0, wr_data},    32'd0);
    check("mid_rst_busy",    {31'd0, busy},       32'd0);
    check("mid_rst_done",    {31'd0, done},       32'd0);
    check("mid_rst_error",   {31'd0, error},      32'd0);
    check("mid_rst_cpu_en",  {31'd0, cpu_enable}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) send_bits(16'($urandom), 16, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check("final_queue_empty", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
